// File: rtl/audio_clip_player.sv
// Multi-clip flash playback engine: programmable clip table, one-read-outstanding fetch, decimated AC97 feed.
// Optional `VOLUME_EN adds a volume_shift input that arithmetic-right-shifts each sample as it is loaded.
module audio_clip_player #(
  parameter int NUM_CLIPS        = 4,
  parameter int ADDR_W           = 23,
  parameter int FLASH_W          = 16,
  parameter int SAMPLE_W         = 8,
  parameter int DECIM            = 8,
  parameter int DEFAULT_CLIP_LEN = 12000,
  localparam int IDX_W = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                trigger,
  input  logic [IDX_W-1:0]    clip_sel,
  input  logic                loop_en,
  input  logic                stop,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_start,
  input  logic [ADDR_W-1:0]   cfg_end,
  input  logic                ready,
`ifdef VOLUME_EN
  input  logic [2:0]          volume_shift,
`endif
  output logic [SAMPLE_W-1:0] to_ac97_data,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_valid,
  input  logic [FLASH_W-1:0]  rd_data,
  output logic                playing,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_DRAIN} state_t;

  logic [ADDR_W-1:0] r_tbl_start [NUM_CLIPS];
  logic [ADDR_W-1:0] r_tbl_end   [NUM_CLIPS];

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_cur_start, w_cur_start_next;
  logic [ADDR_W-1:0]   r_cur_end, w_cur_end_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [SAMPLE_W-1:0] r_next_buf, w_next_buf_next;
  logic                r_nb_full, w_nb_full_next;
  logic [DEC_W-1:0]    r_dec_cnt, w_dec_cnt_next;
  logic [SAMPLE_W-1:0] r_out, w_out_next;
  logic [7:0]          r_underrun, w_underrun_next;
  logic                r_discard, w_discard_next;
  logic                r_done, w_done_next;

  logic                w_strobe0;
  logic                w_at_end;
  logic                w_rd_busy;
  logic [SAMPLE_W-1:0] w_load_sample;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_CLIPS; i++) begin
        r_tbl_start[i] <= ADDR_W'(i * DEFAULT_CLIP_LEN + 1);
        r_tbl_end[i]   <= ADDR_W'((i + 1) * DEFAULT_CLIP_LEN);
      end
    end else if (cfg_we) begin
      r_tbl_start[cfg_idx] <= cfg_start;
      r_tbl_end[cfg_idx]   <= cfg_end;
    end
  end

`ifdef VOLUME_EN
  assign w_load_sample = $signed(r_next_buf) >>> volume_shift;
`else
  assign w_load_sample = r_next_buf;
`endif

  if (FLASH_W > SAMPLE_W) begin : g_unused
    logic w_unused_lsb;
    assign w_unused_lsb = ^rd_data[FLASH_W-SAMPLE_W-1:0];
  end

  assign w_strobe0 = ready && (r_dec_cnt == '0);
  // A reversed range plays only its start word, then ends like a normal clip.
  assign w_at_end  = (r_addr == r_cur_end) || (r_cur_end < r_cur_start);
  // A read is in flight if one is being issued now or an answer is still owed.
  assign w_rd_busy = (r_state == S_FETCH) ||
                     ((r_state == S_WAIT) && !rd_valid) ||
                     ((r_state == S_IDLE) && r_discard && !rd_valid);

  always_comb begin
    w_state_next     = r_state;
    w_cur_start_next = r_cur_start;
    w_cur_end_next   = r_cur_end;
    w_addr_next      = r_addr;
    w_next_buf_next  = r_next_buf;
    w_nb_full_next   = r_nb_full;
    w_dec_cnt_next   = r_dec_cnt;
    w_out_next       = r_out;
    w_underrun_next  = r_underrun;
    w_discard_next   = r_discard;
    w_done_next      = 1'b0;

    if (trigger) begin
      w_cur_start_next = r_tbl_start[clip_sel];
      w_cur_end_next   = r_tbl_end[clip_sel];
      w_addr_next      = r_tbl_start[clip_sel];
      w_dec_cnt_next   = '0;
      w_nb_full_next   = 1'b0;
      w_discard_next   = w_rd_busy;
      w_state_next     = w_rd_busy ? S_WAIT : S_FETCH;
    end else if (r_state == S_IDLE) begin
      w_out_next = '0;
      if (rd_valid) w_discard_next = 1'b0;
    end else if (stop) begin
      w_state_next   = S_IDLE;
      w_out_next     = '0;
      w_nb_full_next = 1'b0;
      w_discard_next = w_rd_busy;
    end else begin
      if (ready) w_dec_cnt_next = (r_dec_cnt == DEC_W'(DECIM - 1)) ? '0 : r_dec_cnt + 1'b1;
      case (r_state)
        S_FETCH: w_state_next = S_WAIT;
        S_WAIT: begin
          if (rd_valid) begin
            if (r_discard) begin
              w_discard_next = 1'b0;
              w_state_next   = S_FETCH;
            end else begin
              w_next_buf_next = rd_data[FLASH_W-1 -: SAMPLE_W];
              w_nb_full_next  = 1'b1;
              w_state_next    = S_PLAY;
            end
          end
        end
        S_DRAIN: begin
          if (w_strobe0) begin
            w_done_next  = 1'b1;
            w_out_next   = '0;
            w_state_next = S_IDLE;
          end
        end
        default: ;
      endcase
      if (w_strobe0 && (r_state != S_DRAIN)) begin
        if (r_nb_full) begin
          w_out_next     = w_load_sample;
          w_nb_full_next = 1'b0;
          if (w_at_end && !loop_en) begin
            w_state_next = S_DRAIN;
          end else begin
            w_addr_next  = w_at_end ? r_cur_start : r_addr + 1'b1;
            w_state_next = S_FETCH;
          end
        end else if (r_underrun != 8'hFF) begin
          w_underrun_next = r_underrun + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= S_IDLE;
      r_cur_start <= '0;
      r_cur_end   <= '0;
      r_addr      <= '0;
      r_next_buf  <= '0;
      r_nb_full   <= 1'b0;
      r_dec_cnt   <= '0;
      r_out       <= '0;
      r_underrun  <= '0;
      r_discard   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cur_start <= w_cur_start_next;
      r_cur_end   <= w_cur_end_next;
      r_addr      <= w_addr_next;
      r_next_buf  <= w_next_buf_next;
      r_nb_full   <= w_nb_full_next;
      r_dec_cnt   <= w_dec_cnt_next;
      r_out       <= w_out_next;
      r_underrun  <= w_underrun_next;
      r_discard   <= w_discard_next;
      r_done      <= w_done_next;
    end
  end

  assign to_ac97_data = r_out;
  assign rd_req       = (r_state == S_FETCH);
  assign rd_addr      = rd_req ? r_addr : '0;
  assign playing      = (r_state != S_IDLE);
  assign done         = r_done;
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_audio_clip_player.sv
// Directed bench for audio_clip_player: one DECIM=1 and one DECIM=8 instance, each with a latency-programmable flash model.
module tb_audio_clip_player;
  localparam int AW = 23;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_b, trigger, loop_en, stop, cfg_we, ready;
  logic [1:0]    clip_sel, cfg_idx;
  logic [AW-1:0] cfg_start, cfg_end;

  logic [7:0]    out1, ur1, out8, ur8;
  logic          rd_req1, playing1, done1, rd_req8, playing8, done8;
  logic [AW-1:0] rd_addr1, rd_addr8;
  logic          rd_valid1 = 1'b0, rd_valid8 = 1'b0;
  logic [15:0]   rd_data1 = '0, rd_data8 = '0;

  int total = 0;
  int bad = 0;
  int lat = 2;
  int done_cnt1 = 0, done_cnt8 = 0;
  logic [AW-1:0] addr_q1[$], addr_q8[$];

  audio_clip_player #(.DECIM(1)) u_dut1 (
    .clock(clock), .reset_b(reset_b), .trigger(trigger), .clip_sel(clip_sel), .loop_en(loop_en),
    .stop(stop), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .ready(ready), .to_ac97_data(out1), .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_valid(rd_valid1),
    .rd_data(rd_data1), .playing(playing1), .done(done1), .underrun_cnt(ur1)
  );

  audio_clip_player #(.DECIM(8)) u_dut8 (
    .clock(clock), .reset_b(reset_b), .trigger(trigger), .clip_sel(clip_sel), .loop_en(loop_en),
    .stop(stop), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .ready(ready), .to_ac97_data(out8), .rd_req(rd_req8), .rd_addr(rd_addr8), .rd_valid(rd_valid8),
    .rd_data(rd_data8), .playing(playing8), .done(done8), .underrun_cnt(ur8)
  );

  // Flash models: answer each request with rd_data = addr << 8 after 'lat' cycles.
  int cnt1 = 0, cnt8 = 0;
  logic pend1 = 1'b0, pend8 = 1'b0;
  logic [AW-1:0] a1 = '0, a8 = '0;

  always @(posedge clock) begin
    rd_valid1 <= 1'b0;
    if (rd_req1) begin
      pend1 <= 1'b1; cnt1 <= lat; a1 <= rd_addr1;
    end else if (pend1) begin
      if (cnt1 <= 1) begin
        rd_valid1 <= 1'b1; rd_data1 <= 16'(a1 << 8); pend1 <= 1'b0;
      end else cnt1 <= cnt1 - 1;
    end
  end

  always @(posedge clock) begin
    rd_valid8 <= 1'b0;
    if (rd_req8) begin
      pend8 <= 1'b1; cnt8 <= lat; a8 <= rd_addr8;
    end else if (pend8) begin
      if (cnt8 <= 1) begin
        rd_valid8 <= 1'b1; rd_data8 <= 16'(a8 << 8); pend8 <= 1'b0;
      end else cnt8 <= cnt8 - 1;
    end
  end

  always @(posedge clock) begin
    if (rd_req1) addr_q1.push_back(rd_addr1);
    if (rd_req8) addr_q8.push_back(rd_addr8);
    if (done1) done_cnt1 <= done_cnt1 + 1;
    if (done8) done_cnt8 <= done_cnt8 + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic logic [AW-1:0] last1();
    return (addr_q1.size() > 0) ? addr_q1[addr_q1.size()-1] : 'x;
  endfunction

  function automatic logic [AW-1:0] last8();
    return (addr_q8.size() > 0) ? addr_q8[addr_q8.size()-1] : 'x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input int gap);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic pulse_trig(input logic [1:0] sel, input logic lp);
    clip_sel = sel; loop_en = lp; trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  typedef struct {
    int            lat;
    logic [7:0]    exp_out;
    logic [AW-1:0] exp_addr;
  } play_vec_t;

  typedef struct {
    logic [7:0] exp_out;
    logic       exp_play;
    int         n;
  } seg_vec_t;

  play_vec_t t1[4];
  seg_vec_t  t2[5];
  logic [AW-1:0] exp_loop[6];

  initial begin
    int d8;
    t1[0] = '{2, 8'd1, 23'd2};
    t1[1] = '{2, 8'd2, 23'd3};
    t1[2] = '{2, 8'd3, 23'd4};
    t1[3] = '{20, 8'd4, 23'd5};
    t2[0] = '{8'd100, 1'b1, 8};
    t2[1] = '{8'd101, 1'b1, 8};
    t2[2] = '{8'd102, 1'b1, 8};
    t2[3] = '{8'd103, 1'b1, 8};
    t2[4] = '{8'd0,   1'b0, 1};
    exp_loop[0] = 23'd100; exp_loop[1] = 23'd101; exp_loop[2] = 23'd102;
    exp_loop[3] = 23'd103; exp_loop[4] = 23'd100; exp_loop[5] = 23'd101;

    reset_b = 1'b0; trigger = 1'b0; clip_sel = '0; loop_en = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_end = '0; ready = 1'b0;
    repeat (3) tick();
    check("rst_out", out1, 0);
    check("rst_playing", playing1, 0);
    check("rst_rd_req", rd_req1, 0);
    check("rst_underrun", ur1, 0);
    check("rst_done", done8, 0);
    reset_b = 1'b1;
    tick();

    // Clip 0 at DECIM=1: samples 1,2,3,4 with reads 2,3,4,5 trailing each load
    pulse_trig(2'd0, 1'b0);
    repeat (10) tick();
    check("first_rd_addr", (addr_q1.size() > 0) ? addr_q1[0] : 'x, 1);
    for (int i = 0; i < 4; i++) begin
      lat = t1[i].lat;
      strobe(10);
      check($sformatf("play_out[%0d]", i), out1, t1[i].exp_out);
      check($sformatf("play_addr[%0d]", i), last1(), t1[i].exp_addr);
    end
    check("play_underrun", ur1, 0);

    // Retrigger clip 1 while the read of addr 5 is in flight
    pulse_trig(2'd1, 1'b0);
    lat = 2;
    repeat (30) tick();
    check("retrig_rd_addr", last1(), 12001);
    check("retrig_playing", playing1, 1);
    strobe(10);
    check("retrig_out", out1, 225);
    check("retrig_next_addr", last1(), 12002);

    pulse_stop();
    repeat (10) tick();
    check("stop_playing", playing1, 0);
    check("stop_out", out1, 0);

    // Clip 2 = {100,103}, DECIM=8, no loop
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_start = 23'd100; cfg_end = 23'd103;
    tick();
    cfg_we = 1'b0;
    pulse_trig(2'd2, 1'b0);
    repeat (10) tick();
    d8 = done_cnt8;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < t2[s].n; k++) begin
        strobe(10);
        check($sformatf("dec_out[%0d.%0d]", s, k), out8, t2[s].exp_out);
        check($sformatf("dec_play[%0d.%0d]", s, k), playing8, t2[s].exp_play);
      end
    end
    check("dec_done_pulses", done_cnt8 - d8, 1);

    // Same clip looping
    addr_q8.delete();
    pulse_trig(2'd2, 1'b1);
    repeat (10) tick();
    d8 = done_cnt8;
    for (int k = 0; k < 33; k++) strobe(10);
    check("loop_addr_count", addr_q8.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("loop_addr[%0d]", i), (addr_q8.size() > i) ? addr_q8[i] : 'x, exp_loop[i]);
    check("loop_out", out8, 100);
    check("loop_no_done", done_cnt8 - d8, 0);
    loop_en = 1'b0;
    pulse_stop();
    repeat (10) tick();
    check("loop_stop_playing", playing8, 0);

    // Late reads at DECIM=1: repeat previous sample, count and saturate underruns
    check("ur_base", ur1, 0);
    pulse_trig(2'd0, 1'b0);
    repeat (10) tick();
    lat = 1000;
    strobe(10);
    check("ur_first_out", out1, 1);
    for (int k = 0; k < 10; k++) strobe(3);
    check("ur_count10", ur1, 10);
    check("ur_hold_out", out1, 1);
    for (int k = 0; k < 260; k++) strobe(3);
    check("ur_saturate", ur1, 255);
    check("ur_hold_out2", out1, 1);
    repeat (300) tick();
    lat = 2;
    strobe(10);
    check("ur_recover_out", out1, 2);

    // Trigger + stop + table write to the same entry in one cycle
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_start = 23'd500; cfg_end = 23'd600;
    clip_sel = 2'd3; trigger = 1'b1; stop = 1'b1;
    tick();
    cfg_we = 1'b0; trigger = 1'b0; stop = 1'b0;
    repeat (10) tick();
    check("trigstop_playing", playing1, 1);
    check("trigstop_rd_addr", last1(), 36001);
    strobe(10);
    check("trigstop_out", out1, 161);

    // Async reset while a read is outstanding
    lat = 20;
    strobe(4);
    check("rstwait_out", out1, 162);
    #2 reset_b = 1'b0;
    #1;
    check("async_rst_out", out1, 0);
    check("async_rst_playing", playing1, 0);
    check("async_rst_underrun", ur1, 0);
    tick();
    reset_b = 1'b1;
    repeat (30) tick();
    check("post_rst_playing", playing1, 0);
    check("post_rst_out", out1, 0);
    lat = 2;
    pulse_trig(2'd2, 1'b0);
    repeat (10) tick();
    check("default_tbl_addr1", last1(), 24001);
    check("default_tbl_addr8", last8(), 24001);
    strobe(10);
    check("default_tbl_out1", out1, 193);
    check("default_tbl_out8", out8, 193);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_clip_player.md
Name: audio_clip_player

Overview:
Parametrised multi-clip playback engine. It replaces the hard-coded start-address case and the address-bump loop inside the audio manager. It holds a programmable table of NUM_CLIPS start/end flash addresses and fetches samples through the flash manager's read interface. It then feeds the AC97 output once per ready strobe, or once per DECIM strobes, with loop, retrigger and underrun handling.

Parameters:
NUM_CLIPS, 4, number of clip table entries (≥2)
ADDR_W, 23, flash word address width
FLASH_W, 16, flash read data width
SAMPLE_W, 8, PCM width to AC97; taken from rd_data[FLASH_W-1 -: SAMPLE_W]
DECIM, 8, ready strobes per stored sample (1 = 48 kHz, 8 = 6 kHz)
DEFAULT_CLIP_LEN, 12000, reset clip length used to fill the table

Ports:
clock  in  1  27 MHz system clock
reset_b  in  1  asynchronous active-low reset
trigger  in  1  single-cycle start pulse
clip_sel  in  $clog2(NUM_CLIPS)  clip index, sampled with trigger
loop_en  in  1  1 = wrap to the clip start at the clip end
stop  in  1  single-cycle abort pulse
cfg_we  in  1  clip table write strobe
cfg_idx  in  $clog2(NUM_CLIPS)  table entry to write
cfg_start  in  ADDR_W  start address
cfg_end  in  ADDR_W  end address (inclusive)
ready  in  1  AC97 sample strobe, one cycle
to_ac97_data  out  SAMPLE_W  PCM sample to headphone
rd_req  out  1  one-cycle read request to the flash manager
rd_addr  out  ADDR_W  read address, valid while rd_req is high
rd_valid  in  1  one-cycle pulse; rd_data is valid
rd_data  in  FLASH_W  flash word
playing  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse at the natural end of a non-looping clip
underrun_cnt  out  8  saturating count of ready strobes with no fresh sample

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; table[i] = {i*DEFAULT_CLIP_LEN+1, (i+1)*DEFAULT_CLIP_LEN}.
- Table write: on cfg_we, update the entry next cycle. The active clip keeps its latched start/end; the new values apply at the next trigger.
- States: IDLE, FETCH, WAIT, PLAY, DRAIN.
- IDLE: to_ac97_data = 0. On trigger, latch cur = table[clip_sel] and set addr = cur.start, then go to FETCH.
- FETCH: assert rd_req for one cycle with rd_addr = addr, then go to WAIT.
- WAIT: on rd_valid, store the sample in next_buf, set nb_full = 1, go to PLAY.
- PLAY, per ready strobe:
  - Increment the decimation counter (0..DECIM-1).
  - When the counter is 0: if nb_full, load next_buf to to_ac97_data the cycle after the strobe and clear nb_full; else hold the previous value and increment underrun_cnt (saturate at 255).
  - After a successful load, advance addr:
    - addr == cur.end and loop_en: addr = cur.start, then FETCH.
    - addr == cur.end and !loop_en: go to DRAIN.
    - otherwise: addr+1, then FETCH.
  - Only one read is outstanding at any time.
- DRAIN: on the next counter-0 strobe, pulse done and go to IDLE. The last sample is output for DECIM strobes before the output returns to 0.
- Retrigger in any non-IDLE state: latch the new clip and reset the decimation counter.
  - If a read is outstanding (WAIT), set a discard flag. The next rd_valid is dropped, then FETCH the new start.
  - Otherwise clear nb_full and go to FETCH.
  - No done pulse is issued.
- stop: next state is IDLE; to_ac97_data = 0; no done pulse. A pending rd_valid is ignored via the discard flag. trigger has priority over a simultaneous stop.
- trigger and cfg_we to the same index in the same cycle: trigger uses the old table value.
- cur.end < cur.start: the clip plays exactly one sample (cur.start), then behaves as at the end.
- Address arithmetic is modulo 2^ADDR_W.
- Reset mid-read: a rd_valid arriving after reset release while IDLE is ignored.

Optional Feature:
VOLUME_EN.
- Defined: adds input port volume_shift [2:0]. The output sample is treated as signed and arithmetic-right-shifted by volume_shift before loading into to_ac97_data. volume_shift is sampled at each load.
- Undefined: no port; the sample passes unmodified.

Test Plan:
- Reset, DECIM=1, trigger clip 0 with rd_data = addr<<8 and 2-cycle read latency -> rd_addr 1,2,3…; to_ac97_data = 1,2,3… on successive ready strobes; underrun_cnt = 0.
- Program clip 2 = {100,103}, loop_en=0, DECIM=8, trigger -> each of samples 100–103 is held for 8 strobes, then one done pulse, then output 0 and playing=0.
- Same clip with loop_en=1 -> address sequence 100,101,102,103,100…; no done pulse.
- Retrigger clip 1 while in WAIT for addr 5 -> the data for addr 5 is never output; next rd_addr = 12001.
- Read latency longer than the strobe interval (DECIM=1) -> previous sample repeated; underrun_cnt increments once per late strobe and saturates at 255.
- stop and trigger in the same cycle; async reset asserted during WAIT -> trigger wins; after reset, outputs are 0 and the table is at its defaults.
